// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS CPU. Decodes opcode/funct from the
// instruction register and steps the shared datapath through fetch, decode,
// execute, memory and write-back. State is registered; control outputs are a
// Moore-style decode of the current state, with opcode/funct/zero where needed.
module multi_cycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       ext_op,
    output logic       lui_op,
    output logic [2:0] alu_op,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EX_R     = 4'd6,
        S_EX_I     = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BR       = 4'd9,
        S_JUMP     = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_FUNC = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    // Shift-by-immediate R-types (sll/srl/sra) take operand A from shamt.
    function automatic logic is_shift_imm(input logic [5:0] fn);
        return (fn == 6'h00) || (fn == 6'h02) || (fn == 6'h03);
    endfunction

    // jr is an R-type encoding that must go to JUMP instead of EX_R.
    function automatic logic is_jr(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_RTYPE) && (fn == FN_JR);
    endfunction

    state_t state_r;
    state_t next_state_s;

    // State register; reset aborts any instruction and returns to IF.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= state_t'(RESET_STATE);
        end else begin
            state_r <= next_state_s;
        end
    end

    assign state = state_r;

    // Next-state and control decode; write enables are masked while reset is high.
    always_comb begin
        next_state_s = S_IF;
        pc_write     = 1'b0;
        i_or_d       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 2'b00;
        mem_to_reg   = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        pc_source    = 2'b00;
        ext_op       = 1'b0;
        lui_op       = 1'b0;
        alu_op       = ALU_ADD;
        illegal      = 1'b0;

        case (state_r)
            S_IF: begin
                mem_read     = 1'b1;
                ir_write     = 1'b1;
                alu_src_b    = 2'b01;
                pc_write     = 1'b1;
                next_state_s = S_ID;
            end
            S_ID: begin
                alu_src_b = 2'b11;
                ext_op    = 1'b1;
                case (opcode)
                    OP_LW, OP_SW: next_state_s = S_MEM_ADDR;
                    OP_RTYPE: begin
                        if (is_jr(opcode, funct)) begin
                            next_state_s = S_JUMP;
                        end else begin
                            next_state_s = S_EX_R;
                        end
                    end
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                    OP_ANDI, OP_ORI, OP_XORI, OP_LUI: next_state_s = S_EX_I;
                    OP_BEQ, OP_BNE: next_state_s = S_BR;
                    OP_J, OP_JAL:   next_state_s = S_JUMP;
                    default: begin
                        illegal      = 1'b1;
                        next_state_s = S_IF;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
                if (opcode == OP_LW) begin
                    next_state_s = S_MEM_RD;
                end else if (opcode == OP_SW) begin
                    next_state_s = S_MEM_WR;
                end else begin
                    next_state_s = S_IF;
                end
            end
            S_MEM_RD: begin
                mem_read     = 1'b1;
                i_or_d       = 1'b1;
                next_state_s = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EX_R: begin
                alu_op       = ALU_FUNC;
                alu_src_a    = is_shift_imm(funct) ? 2'b10 : 2'b01;
                next_state_s = S_ALU_WB;
            end
            S_EX_I: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                next_state_s = S_ALU_WB;
                case (opcode)
                    OP_ADDI, OP_ADDIU: begin alu_op = ALU_ADD;  ext_op = 1'b1; end
                    OP_SLTI:           begin alu_op = ALU_SLT;  ext_op = 1'b1; end
                    OP_SLTIU:          begin alu_op = ALU_SLTU; ext_op = 1'b1; end
                    OP_ANDI:           alu_op = ALU_AND;
                    OP_ORI:            alu_op = ALU_OR;
                    OP_XORI:           alu_op = ALU_XOR;
                    OP_LUI:            begin alu_op = ALU_OR;   lui_op = 1'b1; end
                    default:           alu_op = ALU_ADD;
                endcase
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = (opcode == OP_RTYPE) ? 2'b01 : 2'b00;
            end
            S_BR: begin
                alu_src_a = 2'b01;
                alu_op    = ALU_SUB;
                pc_source = 2'b01;
                if (opcode == OP_BEQ) begin
                    pc_write = zero;
                end else if (opcode == OP_BNE) begin
                    pc_write = ~zero;
                end else begin
                    pc_write = 1'b0;
                end
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = is_jr(opcode, funct) ? 2'b11 : 2'b10;
                if (opcode == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end else begin
                    reg_write  = 1'b0;
                end
            end
            default: next_state_s = S_IF;
        endcase

        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            illegal   = 1'b0;
        end else begin
            illegal   = illegal;
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: each cycle's expected control word is
// queued alongside the stimulus and compared against the DUT at mid-cycle.
module tb_multi_cycle_ctrl;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       ext_op;
        logic       lui_op;
        logic [2:0] alu_op;
        logic       illegal;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source;
    logic       ext_op, lui_op, illegal;
    logic [2:0] alu_op;
    logic [3:0] state;

    ctl_t obs;
    ctl_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl #(.RESET_STATE(4'd0)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_source(pc_source), .ext_op(ext_op),
        .lui_op(lui_op), .alu_op(alu_op), .illegal(illegal), .state(state)
    );

    assign obs = {state, pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write,
                  reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source,
                  ext_op, lui_op, alu_op, illegal};

    function automatic ctl_t st(input logic [3:0] s);
        ctl_t c = '0;
        c.state = s;
        return c;
    endfunction

    function automatic ctl_t e_if();
        ctl_t c = st(4'd0);
        c.pc_write = 1'b1; c.mem_read = 1'b1; c.ir_write = 1'b1; c.alu_src_b = 2'b01;
        return c;
    endfunction

    function automatic ctl_t e_id();
        ctl_t c = st(4'd1);
        c.alu_src_b = 2'b11; c.ext_op = 1'b1;
        return c;
    endfunction

    // Compare the DUT against the oldest queued expectation, then advance a cycle.
    task automatic step(input string tag);
        ctl_t e;
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        ctl_t e;
        reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
        @(negedge clk); @(negedge clk);

        // lw: 0,1,2,3,4
        reset = 1'b0; opcode = 6'h23;
        exp_q.push_back(e_if()); exp_q.push_back(e_id());
        e = st(4'd2); e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.ext_op = 1'b1; exp_q.push_back(e);
        e = st(4'd3); e.mem_read = 1'b1; e.i_or_d = 1'b1; exp_q.push_back(e);
        e = st(4'd4); e.reg_write = 1'b1; e.mem_to_reg = 2'b01; exp_q.push_back(e);
        run("lw", 5);

        // lw interrupted by 3 cycles of reset in MEM_RD
        exp_q.push_back(e_if()); exp_q.push_back(e_id());
        e = st(4'd2); e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.ext_op = 1'b1; exp_q.push_back(e);
        run("lw_pre_reset", 3);
        reset = 1'b1;
        e = st(4'd3); e.i_or_d = 1'b1; exp_q.push_back(e);
        step("reset_in_mem_rd");
        e = st(4'd0); e.alu_src_b = 2'b01; exp_q.push_back(e); exp_q.push_back(e);
        run("reset_held_if", 2);
        reset = 1'b0;

        // sll: 0,1,6,8
        opcode = 6'h00; funct = 6'h00;
        exp_q.push_back(e_if()); exp_q.push_back(e_id());
        e = st(4'd6); e.alu_src_a = 2'b10; e.alu_op = 3'b010; exp_q.push_back(e);
        e = st(4'd8); e.reg_write = 1'b1; e.reg_dst = 2'b01; exp_q.push_back(e);
        run("sll", 4);

        // add (funct 0x20) takes A from the register file
        funct = 6'h20;
        exp_q.push_back(e_if()); exp_q.push_back(e_id());
        e = st(4'd6); e.alu_src_a = 2'b01; e.alu_op = 3'b010; exp_q.push_back(e);
        e = st(4'd8); e.reg_write = 1'b1; e.reg_dst = 2'b01; exp_q.push_back(e);
        run("add", 4);

        // addi, ori, lui, slti through EX_I
        opcode = 6'h08;
        exp_q.push_back(e_if()); exp_q.push_back(e_id());
        e = st(4'd7); e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.ext_op = 1'b1; exp_q.push_back(e);
        e = st(4'd8); e.reg_write = 1'b1; exp_q.push_back(e);
        run("addi", 4);
        opcode = 6'h0D;
        exp_q.push_back(e_if()); exp_q.push_back(e_id());
        e = st(4'd7); e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.alu_op = 3'b100; exp_q.push_back(e);
        e = st(4'd8); e.reg_write = 1'b1; exp_q.push_back(e);
        run("ori", 4);
        opcode = 6'h0F;
        exp_q.push_back(e_if()); exp_q.push_back(e_id());
        e = st(4'd7); e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.alu_op = 3'b100; e.lui_op = 1'b1; exp_q.push_back(e);
        e = st(4'd8); e.reg_write = 1'b1; exp_q.push_back(e);
        run("lui", 4);
        opcode = 6'h0A;
        exp_q.push_back(e_if()); exp_q.push_back(e_id());
        e = st(4'd7); e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.alu_op = 3'b110; e.ext_op = 1'b1; exp_q.push_back(e);
        e = st(4'd8); e.reg_write = 1'b1; exp_q.push_back(e);
        run("slti", 4);

        // Branches: beq taken/not, bne taken/not
        for (int k = 0; k < 4; k++) begin
            opcode = (k < 2) ? 6'h04 : 6'h05;
            zero   = k[0];
            exp_q.push_back(e_if()); exp_q.push_back(e_id());
            e = st(4'd9); e.alu_src_a = 2'b01; e.alu_op = 3'b001; e.pc_source = 2'b01;
            e.pc_write = (k < 2) ? k[0] : ~k[0];
            exp_q.push_back(e);
            run((k < 2) ? "beq" : "bne", 3);
        end
        zero = 1'b0;

        // jal, j, jr
        opcode = 6'h03;
        exp_q.push_back(e_if()); exp_q.push_back(e_id());
        e = st(4'd10); e.pc_write = 1'b1; e.pc_source = 2'b10; e.reg_write = 1'b1;
        e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; exp_q.push_back(e);
        run("jal", 3);
        opcode = 6'h02;
        exp_q.push_back(e_if()); exp_q.push_back(e_id());
        e = st(4'd10); e.pc_write = 1'b1; e.pc_source = 2'b10; exp_q.push_back(e);
        run("j", 3);
        opcode = 6'h00; funct = 6'h08;
        exp_q.push_back(e_if()); exp_q.push_back(e_id());
        e = st(4'd10); e.pc_write = 1'b1; e.pc_source = 2'b11; exp_q.push_back(e);
        run("jr", 3);

        // Illegal opcode: pulse in ID then back to IF
        opcode = 6'h3F;
        exp_q.push_back(e_if());
        e = e_id(); e.illegal = 1'b1; exp_q.push_back(e);
        run("illegal", 2);

        // sw with reset in MEM_WR suppresses the store
        opcode = 6'h2B;
        exp_q.push_back(e_if()); exp_q.push_back(e_id());
        e = st(4'd2); e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.ext_op = 1'b1; exp_q.push_back(e);
        run("sw", 3);
        reset = 1'b1;
        e = st(4'd5); e.i_or_d = 1'b1; exp_q.push_back(e);
        step("reset_in_mem_wr");
        reset = 1'b0;
        exp_q.push_back(e_if());
        step("if_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
